// File: rtl/sim_host_mmio_if.sv
// Bus bundle between the data-memory decoder (or bench) and the simulation host responder.
// Register-access strobes plus the console drain and end-of-test status lines.
interface sim_host_mmio_if #(
    parameter int DATAWIDTH     = 32,
    parameter int ADDR_BITWIDTH = 5
);
    logic                     SIMHOST_Sel_in;
    logic                     SIMHOST_We;
    logic                     SIMHOST_Re;
    logic [3:0]               SIMHOST_Byteenable;
    logic [ADDR_BITWIDTH-1:0] SIMHOST_Address;
    logic [DATAWIDTH-1:0]     SIMHOST_Data_In;
    logic [DATAWIDTH-1:0]     SIMHOST_Data_Out;
    logic                     SIMHOST_Con_Valid_out;
    logic [7:0]               SIMHOST_Con_Data_out;
    logic                     SIMHOST_Con_Ready_in;
    logic                     SIMHOST_Done_out;
    logic                     SIMHOST_Pass_out;
    logic [DATAWIDTH-2:0]     SIMHOST_Code_out;

    modport slave (
        input  SIMHOST_Sel_in, SIMHOST_We, SIMHOST_Re, SIMHOST_Byteenable,
               SIMHOST_Address, SIMHOST_Data_In, SIMHOST_Con_Ready_in,
        output SIMHOST_Data_Out, SIMHOST_Con_Valid_out, SIMHOST_Con_Data_out,
               SIMHOST_Done_out, SIMHOST_Pass_out, SIMHOST_Code_out
    );

    modport master (
        output SIMHOST_Sel_in, SIMHOST_We, SIMHOST_Re, SIMHOST_Byteenable,
               SIMHOST_Address, SIMHOST_Data_In, SIMHOST_Con_Ready_in,
        input  SIMHOST_Data_Out, SIMHOST_Con_Valid_out, SIMHOST_Con_Data_out,
               SIMHOST_Done_out, SIMHOST_Pass_out, SIMHOST_Code_out
    );
endinterface

// File: rtl/sim_host_mmio.sv
// Memory-mapped simulation host: cycle counter, tohost pass/fail, console byte FIFO, timeout.
// state     | meaning
// S_RUN     | program running, CYCLE counting, watching TOHOST and timeout
// S_DONE    | program wrote TOHOST with bit0 set; code latched, terminal
// S_TIMEOUT | CYCLE reached TIMEOUT before a done write; terminal
module sim_host_mmio #(
    parameter int DATAWIDTH       = 32,
    parameter int ADDR_BITWIDTH   = 5,
    parameter int FIFO_DEPTH      = 16,
    parameter int TIMEOUT_DEFAULT = 5000
) (
    input  logic           SIMHOST_Clk_in,
    input  logic           SIMHOST_Reset_in,
    sim_host_mmio_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam int WW    = ADDR_BITWIDTH - 2;
    localparam logic [WW-1:0] A_CYCLE   = WW'(0);
    localparam logic [WW-1:0] A_TOHOST  = WW'(1);
    localparam logic [WW-1:0] A_CONSOLE = WW'(2);
    localparam logic [WW-1:0] A_TIMEOUT = WW'(3);
    localparam logic [WW-1:0] A_STATUS  = WW'(4);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_DONE = 2'd1, S_TIMEOUT = 2'd2} state_t;

    state_t               r_state, w_state_next;
    logic [DATAWIDTH-1:0] r_cycle, r_timeout, r_data_out, w_rdata;
    logic [DATAWIDTH-2:0] r_code;
    logic [7:0]           r_fifo [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr, w_count;
    logic                 r_ovf;
    logic [WW-1:0]        w_word;
    logic [3:0]           w_count_sat;
    logic                 w_wr, w_rd, w_done_wr, w_timeout_hit;
    logic                 w_empty, w_full, w_push_req, w_push, w_pop;
    logic                 w_unused;

    assign w_word        = bus.SIMHOST_Address[ADDR_BITWIDTH-1:2];
    assign w_unused      = ^bus.SIMHOST_Address[1:0];
    assign w_wr          = bus.SIMHOST_Sel_in & bus.SIMHOST_We;
    assign w_rd          = bus.SIMHOST_Sel_in & bus.SIMHOST_Re;
    assign w_done_wr     = w_wr && (w_word == A_TOHOST) && bus.SIMHOST_Data_In[0];
    // A zero TIMEOUT disables the check; a value at or below CYCLE only fires after wrap.
    assign w_timeout_hit = (r_timeout != '0) && (r_cycle == r_timeout - DATAWIDTH'(1));

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop      = !w_empty && bus.SIMHOST_Con_Ready_in;
    assign w_push_req = w_wr && (w_word == A_CONSOLE) && bus.SIMHOST_Byteenable[0];
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_count_sat = (32'(w_count) > 15) ? 4'hF : 4'(w_count);

    always_comb begin
        w_rdata = '0;
        case (w_word)
            A_CYCLE:   w_rdata = r_cycle;
            A_TIMEOUT: w_rdata = r_timeout;
            A_STATUS:  w_rdata[5:0] = {r_ovf, w_count_sat, r_state == S_TIMEOUT};
            default:   ;
        endcase
    end

    always_ff @(posedge SIMHOST_Clk_in or posedge SIMHOST_Reset_in) begin
        if (SIMHOST_Reset_in) r_state <= S_RUN;
        else                  r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (w_done_wr)          w_state_next = S_DONE;
                else if (w_timeout_hit) w_state_next = S_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.SIMHOST_Done_out = (r_state != S_RUN);
        bus.SIMHOST_Pass_out = (r_state == S_DONE) && (r_code == '0);
    end

    always_ff @(posedge SIMHOST_Clk_in or posedge SIMHOST_Reset_in) begin
        if (SIMHOST_Reset_in) begin
            r_cycle    <= '0;
            r_timeout  <= DATAWIDTH'(TIMEOUT_DEFAULT);
            r_data_out <= '0;
            r_code     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_state == S_RUN) r_cycle <= r_cycle + DATAWIDTH'(1);
            if (w_rd) r_data_out <= w_rdata;
            if (w_wr && (w_word == A_TIMEOUT)) begin
                for (int b = 0; b < DATAWIDTH / 8; b++) begin
                    if (bus.SIMHOST_Byteenable[b]) r_timeout[b*8 +: 8] <= bus.SIMHOST_Data_In[b*8 +: 8];
                end
            end
            if ((r_state == S_RUN) && w_done_wr) r_code <= bus.SIMHOST_Data_In[DATAWIDTH-1:1];
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge SIMHOST_Clk_in) begin
        if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= bus.SIMHOST_Data_In[7:0];
    end

    assign bus.SIMHOST_Data_Out      = r_data_out;
    assign bus.SIMHOST_Code_out      = r_code;
    assign bus.SIMHOST_Con_Valid_out = !w_empty;
    assign bus.SIMHOST_Con_Data_out  = w_empty ? 8'h00 : r_fifo[r_rd_ptr[PTR_W-1:0]];
endmodule
